// File: rtl/cmd_input_conditioner_if.sv
// Pin-side bundle of the command input conditioner: raw board inputs in,
// clean command word and single-cycle button pulses out.
interface cmd_input_conditioner_if;
    logic [2:0] sw_cmd_raw;
    logic       btn_confirm_raw;
    logic       btn_exit_raw;
    logic [2:0] command;
    logic       btn_confirm;
    logic       btn_exit;

    modport master (
        output sw_cmd_raw,
        output btn_confirm_raw,
        output btn_exit_raw,
        input  command,
        input  btn_confirm,
        input  btn_exit
    );

    modport slave (
        input  sw_cmd_raw,
        input  btn_confirm_raw,
        input  btn_exit_raw,
        output command,
        output btn_confirm,
        output btn_exit
    );
endinterface

// File: rtl/cmd_input_conditioner.sv
// Synchronises and debounces the confirm/exit buttons and the 3-bit command switches.
// Optional feature macro LONG_PRESS_EN: a long confirm hold also emits one btn_exit pulse.
module cmd_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES   = 32'd1_000_000,
    parameter int unsigned LONG_PRESS_CYCLES = 32'd100_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cmd_input_conditioner_if.slave bus
);

    localparam int unsigned DCW = (DEBOUNCE_CYCLES > 32'd1) ? $clog2(DEBOUNCE_CYCLES) : 32'd1;
    // Command counter saturates at D-1; button counter fires at D-2 so the entry
    // cycle into PRESS_WAIT already counts as the first stable sample.
    localparam logic [DCW-1:0] CMD_LAST = DCW'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [DCW-1:0] BTN_LAST = DCW'((DEBOUNCE_CYCLES > 32'd1) ?
                                               (DEBOUNCE_CYCLES - 32'd2) : 32'd0);
    localparam int CH_CONFIRM = 0;
    localparam int CH_EXIT    = 1;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    logic [4:0]     sync1_r;
    logic [4:0]     sync2_r;
    logic [2:0]     sw_sync_s;
    logic [1:0]     btn_sync_s;

    btn_state_e     btn_state_r [2];
    logic [DCW-1:0] btn_cnt_r   [2];
    logic [1:0]     btn_fire_s;

    logic [2:0]     cand_r;
    logic [DCW-1:0] cmd_cnt_r;
    logic           cmd_eligible_s;
    logic           cmd_update_s;
    logic           long_fire_s;

    logic [2:0]     command_r;
    logic           btn_confirm_r;
    logic           btn_exit_r;

    // Two-flop synchroniser for all raw inputs, packed as {switches, exit, confirm}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 5'b0_0000;
            sync2_r <= 5'b0_0000;
        end else begin
            sync1_r <= {bus.sw_cmd_raw, bus.btn_exit_raw, bus.btn_confirm_raw};
            sync2_r <= sync1_r;
        end
    end

    // Unpack the synchronised word into the switch word and button levels.
    always_comb begin
        sw_sync_s  = sync2_r[4:2];
        btn_sync_s = sync2_r[1:0];
    end

    // Press acceptance strobe: the cycle the debounce of a press completes.
    always_comb begin
        btn_fire_s = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
            btn_fire_s[ch] = (btn_state_r[ch] == PRESS_WAIT) && btn_sync_s[ch] &&
                             (btn_cnt_r[ch] == BTN_LAST);
        end
    end

    // Button debounce FSMs, one per channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < 2; ch++) begin
                btn_state_r[ch] <= RELEASED;
                btn_cnt_r[ch]   <= '0;
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                case (btn_state_r[ch])
                    RELEASED: begin
                        btn_cnt_r[ch] <= '0;
                        if (btn_sync_s[ch]) begin
                            btn_state_r[ch] <= PRESS_WAIT;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!btn_sync_s[ch]) begin
                            btn_state_r[ch] <= RELEASED;
                            btn_cnt_r[ch]   <= '0;
                        end else if (btn_cnt_r[ch] == BTN_LAST) begin
                            btn_state_r[ch] <= PRESSED;
                            btn_cnt_r[ch]   <= '0;
                        end else begin
                            btn_cnt_r[ch] <= btn_cnt_r[ch] + DCW'(1'b1);
                        end
                    end
                    PRESSED: begin
                        btn_cnt_r[ch] <= '0;
                        if (!btn_sync_s[ch]) begin
                            btn_state_r[ch] <= RELEASE_WAIT;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (btn_sync_s[ch]) begin
                            btn_state_r[ch] <= PRESSED;
                            btn_cnt_r[ch]   <= '0;
                        end else if (btn_cnt_r[ch] == BTN_LAST) begin
                            btn_state_r[ch] <= RELEASED;
                            btn_cnt_r[ch]   <= '0;
                        end else begin
                            btn_cnt_r[ch] <= btn_cnt_r[ch] + DCW'(1'b1);
                        end
                    end
                    default: begin
                        btn_state_r[ch] <= RELEASED;
                        btn_cnt_r[ch]   <= '0;
                    end
                endcase
            end
        end
    end

    // Command candidate tracking: any change restarts the stability count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_r    <= 3'b000;
            cmd_cnt_r <= '0;
        end else if (sw_sync_s != cand_r) begin
            cand_r    <= sw_sync_s;
            cmd_cnt_r <= '0;
        end else if (cmd_cnt_r != CMD_LAST) begin
            cmd_cnt_r <= cmd_cnt_r + DCW'(1'b1);
        end else begin
            cmd_cnt_r <= cmd_cnt_r;
        end
    end

    // A stable candidate may reach the output only while confirm is idle and
    // not firing, so a confirm pulse always sees the pre-update command.
    always_comb begin
        cmd_eligible_s = (sw_sync_s == cand_r) && (cmd_cnt_r == CMD_LAST);
        cmd_update_s   = cmd_eligible_s &&
                         ((btn_state_r[CH_CONFIRM] == RELEASED) ||
                          (btn_state_r[CH_CONFIRM] == PRESS_WAIT)) &&
                         !btn_fire_s[CH_CONFIRM];
    end

`ifdef LONG_PRESS_EN
    localparam int unsigned HCW = $clog2(LONG_PRESS_CYCLES + 32'd1);
    localparam logic [HCW-1:0] HOLD_MAX  = HCW'(LONG_PRESS_CYCLES);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(LONG_PRESS_CYCLES - 32'd1);

    logic [HCW-1:0] hold_cnt_r;
    logic           long_done_r;

    // Long-press strobe, at most once until confirm fully releases.
    always_comb begin
        long_fire_s = (btn_state_r[CH_CONFIRM] == PRESSED) &&
                      (hold_cnt_r == HOLD_LAST) && !long_done_r;
    end

    // Hold counter runs only in PRESSED; the done flag survives release bounce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_r  <= '0;
            long_done_r <= 1'b0;
        end else begin
            if (btn_state_r[CH_CONFIRM] != PRESSED) begin
                hold_cnt_r <= '0;
            end else if (hold_cnt_r != HOLD_MAX) begin
                hold_cnt_r <= hold_cnt_r + HCW'(1'b1);
            end else begin
                hold_cnt_r <= hold_cnt_r;
            end

            if (btn_state_r[CH_CONFIRM] == RELEASED) begin
                long_done_r <= 1'b0;
            end else if (long_fire_s) begin
                long_done_r <= 1'b1;
            end else begin
                long_done_r <= long_done_r;
            end
        end
    end
`else
    // Without long-press support exit pulses come only from the exit button.
    always_comb begin
        long_fire_s = 1'b0;
    end
`endif

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            command_r     <= 3'b000;
            btn_confirm_r <= 1'b0;
            btn_exit_r    <= 1'b0;
        end else begin
            if (cmd_update_s) begin
                command_r <= cand_r;
            end else begin
                command_r <= command_r;
            end
            btn_confirm_r <= btn_fire_s[CH_CONFIRM];
            btn_exit_r    <= btn_fire_s[CH_EXIT] | long_fire_s;
        end
    end

    assign bus.command     = command_r;
    assign bus.btn_confirm = btn_confirm_r;
    assign bus.btn_exit    = btn_exit_r;

endmodule

// File: tb/tb_cmd_input_conditioner.sv
// Scoreboard bench for cmd_input_conditioner with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20.
module tb_cmd_input_conditioner;

    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 20;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cmd_input_conditioner_if bus_if ();

    cmd_input_conditioner #(
        .DEBOUNCE_CYCLES   (DEB),
        .LONG_PRESS_CYCLES (LONG)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    typedef struct {
        int         cyc;
        logic       conf;
        logic       ex;
        logic [2:0] cmd;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        mon_ev;
    int         cyc       = 0;
    int         tests     = 0;
    int         fails     = 0;
    int         conf_seen = 0;
    int         exit_seen = 0;
    logic [2:0] prev_cmd  = 3'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic expect_ev(input int at, input logic c, input logic e, input logic [2:0] cmd);
        ev_t ev;
        ev.cyc  = at;
        ev.conf = c;
        ev.ex   = e;
        ev.cmd  = cmd;
        exp_q.push_back(ev);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every pulse or command change is matched against the next expected event.
    always @(negedge clk) begin
        if (rst_n === 1'b1 &&
            (bus_if.btn_confirm === 1'b1 || bus_if.btn_exit === 1'b1 || bus_if.command !== prev_cmd)) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: cyc %0d confirm %b exit %b command %0d, required no event",
                         cyc, bus_if.btn_confirm, bus_if.btn_exit, bus_if.command);
            end else begin
                mon_ev = exp_q.pop_front();
                if (mon_ev.cyc != cyc || mon_ev.conf !== bus_if.btn_confirm ||
                    mon_ev.ex !== bus_if.btn_exit || mon_ev.cmd !== bus_if.command) begin
                    fails++;
                    $display("FAIL event: got cyc %0d confirm %b exit %b command %0d, required cyc %0d confirm %b exit %b command %0d",
                             cyc, bus_if.btn_confirm, bus_if.btn_exit, bus_if.command,
                             mon_ev.cyc, mon_ev.conf, mon_ev.ex, mon_ev.cmd);
                end
            end
        end
        if (bus_if.btn_confirm === 1'b1) conf_seen++;
        if (bus_if.btn_exit === 1'b1) exit_seen++;
        prev_cmd = bus_if.command;
    end

    initial begin
        int   k;
        int   base;
        logic bounce [7];
        bounce = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        rst_n                  = 1'b0;
        bus_if.sw_cmd_raw      = 3'd0;
        bus_if.btn_confirm_raw = 1'b0;
        bus_if.btn_exit_raw    = 1'b0;
        step(3);
        check("reset_command", {29'd0, bus_if.command}, 32'd0);
        check("reset_confirm", {31'd0, bus_if.btn_confirm}, 32'd0);
        check("reset_exit", {31'd0, bus_if.btn_exit}, 32'd0);
        rst_n = 1'b1;
        step(3);

        // Clean press held 30 cycles: one pulse at k+2+DEB, none on release.
        k = cyc;
        bus_if.btn_confirm_raw = 1'b1;
        expect_ev(k + 2 + DEB, 1'b1, 1'b0, 3'd0);
`ifdef LONG_PRESS_EN
        expect_ev(k + 2 + DEB + LONG, 1'b0, 1'b1, 3'd0);
`endif
        step(30);
        bus_if.btn_confirm_raw = 1'b0;
        step(12);
        check("clean_single_pulse", conf_seen, 32'd1);

        // Bounce shorter than the debounce window, then a steady press.
        for (int i = 0; i < 7; i++) begin
            bus_if.btn_exit_raw = bounce[i];
            step(1);
        end
        check("bounce_no_exit", exit_seen, 32'd0);
        k = cyc;
        bus_if.btn_exit_raw = 1'b1;
        expect_ev(k + 2 + DEB, 1'b0, 1'b1, 3'd0);
        step(6);
        bus_if.btn_exit_raw = 1'b0;
        step(12);

        // Command update and freeze across a confirm press.
        k = cyc;
        bus_if.sw_cmd_raw = 3'd2;
        expect_ev(k + 3 + DEB, 1'b0, 1'b0, 3'd2);
        step(10);
        check("command_after_change", {29'd0, bus_if.command}, 32'd2);
        k = cyc;
        bus_if.btn_confirm_raw = 1'b1;
        expect_ev(k + 2 + DEB, 1'b1, 1'b0, 3'd2);
        step(8);
        bus_if.sw_cmd_raw = 3'd4;
        step(10);
        check("command_frozen_in_hold", {29'd0, bus_if.command}, 32'd2);
        k = cyc;
        bus_if.btn_confirm_raw = 1'b0;
        // Release debounce ends at k+6; the pending update lands one edge later.
        expect_ev(k + 3 + DEB, 1'b0, 1'b0, 3'd4);
        step(14);

        // Simultaneous confirm and exit presses.
        k = cyc;
        bus_if.btn_confirm_raw = 1'b1;
        bus_if.btn_exit_raw    = 1'b1;
        expect_ev(k + 2 + DEB, 1'b1, 1'b1, 3'd4);
        step(8);
        bus_if.btn_confirm_raw = 1'b0;
        bus_if.btn_exit_raw    = 1'b0;
        step(12);

        // Long confirm hold of 40 cycles.
        base = exit_seen;
        k = cyc;
        bus_if.btn_confirm_raw = 1'b1;
        expect_ev(k + 2 + DEB, 1'b1, 1'b0, 3'd4);
`ifdef LONG_PRESS_EN
        expect_ev(k + 2 + DEB + LONG, 1'b0, 1'b1, 3'd4);
`endif
        step(40);
        bus_if.btn_confirm_raw = 1'b0;
        step(12);
`ifdef LONG_PRESS_EN
        check("long_press_exit_count", exit_seen - base, 32'd1);
`else
        check("long_press_exit_count", exit_seen - base, 32'd0);
`endif

        // Reset in the middle of PRESS_WAIT.
        base = conf_seen;
        bus_if.btn_confirm_raw = 1'b1;
        step(4);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_command", {29'd0, bus_if.command}, 32'd0);
        check("midreset_confirm", {31'd0, bus_if.btn_confirm}, 32'd0);
        check("midreset_exit", {31'd0, bus_if.btn_exit}, 32'd0);
        bus_if.btn_confirm_raw = 1'b0;
        bus_if.sw_cmd_raw      = 3'd0;
        step(3);
        rst_n = 1'b1;
        step(15);
        check("no_pulse_after_reset", conf_seen - base, 32'd0);

        step(5);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cmd_input_conditioner.md
# cmd_input_conditioner

- Upstream front end of the mode controller.
- Synchronises and debounces the raw confirm and exit push-buttons and the 3-bit command switch bank.
- Delivers clean single-cycle `btn_confirm` and `btn_exit` pulses plus a stable registered `command` that never changes under a confirm press.
- Sits between board I/O pins and the central mode FSM.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable synchronised cycles required to accept a level change (10 ms at 100 MHz); legal range ≥ 1.
- `LONG_PRESS_CYCLES`, default 100_000_000: confirm hold length that generates an exit pulse (used only with `LONG_PRESS_EN`); must be > `DEBOUNCE_CYCLES`.
- Counter widths are derived with `$clog2` of the parameters.

Ports:
- `clk` in 1: single system clock. All logic is on its rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `sw_cmd_raw` in 3: raw command switches, asynchronous.
- `btn_confirm_raw` in 1: raw confirm button, active-high, asynchronous.
- `btn_exit_raw` in 1: raw exit button, active-high, asynchronous.
- `command` out 3: debounced, registered command value.
- `btn_confirm` out 1: one-cycle pulse on each accepted confirm press.
- `btn_exit` out 1: one-cycle pulse on each accepted exit press, or on a long press when enabled.

## Operation
- **Synchronisation:** every raw input passes a 2-flop synchroniser, reset to 0. The 3 switch bits are synchronised per bit and debounced as one 3-bit word.
- **Button channels:** confirm and exit each run a 4-state FSM.
  - States: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT. Reset state is RELEASED.
  - RELEASED → PRESS_WAIT when the synced input is 1; the counter clears.
  - PRESS_WAIT: the counter increments each cycle the synced input is 1. If the input returns to 0, go back to RELEASED and clear the counter. When the counter reaches `DEBOUNCE_CYCLES`-1, go to PRESSED and assert the pulse for exactly that transition cycle.
  - PRESSED → RELEASE_WAIT when the synced input is 0.
  - RELEASE_WAIT: requires `DEBOUNCE_CYCLES` consecutive 0 samples to reach RELEASED, with no pulse. A 1 sample returns to PRESSED.
- **Command word:**
  - A candidate register is compared with the synced word.
  - Any mismatch reloads the candidate and clears the stability counter.
  - After `DEBOUNCE_CYCLES` consecutive matches the candidate becomes eligible.
- **Command freeze:**
  - An eligible candidate is copied to `command` only while the confirm FSM is RELEASED or PRESS_WAIT.
  - In the cycle the confirm pulse is asserted, and while confirm is PRESSED or RELEASE_WAIT, the update is held pending. It applies on the first cycle back in RELEASED.
  - In the cycle a confirm pulse is high, the value on `command` is therefore the value before any same-cycle update.
- **Simultaneous events:** confirm and exit pulses in the same cycle are both output unmodified. The consumer gives priority.
- **Reset values:** `command`=3'b000, `btn_confirm`=0, `btn_exit`=0, all FSMs RELEASED, all counters 0.
- **Reset mid-operation:** reset is honoured asynchronously at any point; it aborts any in-flight debounce and produces no pulse.

## Timing
- A raw edge first sampled at edge N reaches the synced output at edge N+2.
- A press held clean produces its pulse at the edge N+1+`DEBOUNCE_CYCLES`. The pulse is high for exactly one cycle.
- `command` updates `DEBOUNCE_CYCLES`+2 edges after a clean switch change, unless frozen.
- Bounce shorter than `DEBOUNCE_CYCLES` cycles produces no output change.
- A held button produces exactly one pulse and no auto-repeat.

## Configuration
- Macro: `LONG_PRESS_EN`.
- **Defined:**
  - The confirm channel has a hold counter that counts while confirm is PRESSED and clears in any other state.
  - When it reaches `LONG_PRESS_CYCLES`, one `btn_exit` pulse is emitted, ORed with the exit channel pulse. There is only one per hold.
  - The confirm pulse at press time is still emitted.
- **Undefined:** no hold counter is built. `btn_exit` comes only from the exit channel.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `LONG_PRESS_CYCLES`=20.
- **Reset:** assert `rst_n`=0 mid-PRESS_WAIT → all outputs 0 immediately; no pulse after release of reset while the button stays at 0.
- **Clean press:** confirm raw rises at edge 10 and is held 30 cycles → `btn_confirm` high only after edge 15; no second pulse; no pulse on release.
- **Bounce rejection:** exit raw toggles 1,1,0,1,1,1,0 → no `btn_exit`. Then a steady 1 for 6 cycles → exactly one pulse.
- **Command freeze:**
  - Set `sw_cmd_raw`=3'd2, wait 10 cycles → `command`=2.
  - Press confirm, then while confirm is held set switches to 3'd4 → `command` stays 2 during the pulse and the hold.
  - Becomes 4 on the first cycle after the confirm FSM returns to RELEASED.
- **Simultaneous:** confirm and exit raw rise on the same edge → both pulses in the same cycle.
- **Long press with `LONG_PRESS_EN`:**
  - Hold confirm for 40 cycles → one `btn_confirm` pulse, then exactly one `btn_exit` pulse 20 cycles after entering PRESSED.
  - Without the macro: the same stimulus gives no `btn_exit`.
